// File: rtl/log_serializer.sv
// Buffers one variable-length record per channel, picks the lowest-index
// pending channel, and sends its bytes MSB-first on a ready/strobe link.
//
// Ports:
//   clk, reset             clock and async active-high reset
//   ch_valid/data/len      per-channel record offer (byte 0 = MSB)
//   ch_ready               per-channel buffer empty
//   ch_inhibit             per-channel exclusion from arbitration
//   tx_ready               downstream can take a byte
//   tx_data, tx_strobe     byte out, strobe one cycle per byte
//   busy                   record transmission in progress
//   drop_count             per-channel saturating dropped-record counters
module log_serializer #(
  parameter int N_CH      = 3,
  parameter int REC_BYTES = 8,
  parameter int LEN_W     = 4,
  parameter int DROP_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              ch_valid,
  input  logic [N_CH*REC_BYTES*8-1:0]  ch_data,
  input  logic [N_CH*LEN_W-1:0]        ch_len,
  output logic [N_CH-1:0]              ch_ready,
  input  logic [N_CH-1:0]              ch_inhibit,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_strobe,
  output logic                         busy,
  output logic [N_CH*DROP_W-1:0]       drop_count
);

  localparam int REC_W = REC_BYTES * 8;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [REC_W-1:0]  buf_data [N_CH];
  logic [LEN_W-1:0]  buf_len  [N_CH];
  logic [N_CH-1:0]   full;
  logic [DROP_W-1:0] drops    [N_CH];
  logic [REC_W-1:0]  shifter;
  logic [LEN_W-1:0]  count;

  logic [N_CH-1:0]   cap;
  logic [N_CH-1:0]   drop_ev;
  logic [LEN_W-1:0]  len_eff  [N_CH];
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              load;

  assign ch_ready = reset ? '0 : ~full;
  assign busy     = (state == SEND);
  assign load     = (state == IDLE) && pick_any;

  // Zero-length offers are ignored entirely: neither captured nor dropped.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      len_eff[i] = ch_len[i*LEN_W +: LEN_W];
      if (len_eff[i] > LEN_W'(REC_BYTES))
        len_eff[i] = LEN_W'(REC_BYTES);
      cap[i]     = ch_valid[i] && ch_ready[i]
                   && (len_eff[i] != '0);
      drop_ev[i] = ch_valid[i] && !ch_ready[i]
                   && (len_eff[i] != '0);
    end
  end

  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!pick_any && full[i] && !ch_inhibit[i]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      drop_count[i*DROP_W +: DROP_W] = drops[i];
  end

  // Channel buffers and drop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
      for (int i = 0; i < N_CH; i++) begin
        buf_data[i] <= '0;
        buf_len[i]  <= '0;
        drops[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load && (pick_idx == IDX_W'(i))) begin
          full[i] <= 1'b0;
        end else if (cap[i]) begin
          full[i]     <= 1'b1;
          buf_data[i] <= ch_data[i*REC_W +: REC_W];
          buf_len[i]  <= len_eff[i];
        end
        if (drop_ev[i] && (drops[i] != '1))
          drops[i] <= drops[i] + 1'b1;
      end
    end
  end

  // Transmit FSM; strobe is never high two cycles running, so a
  // registered downstream ready has time to drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shifter   <= '0;
      count     <= '0;
      tx_data   <= '0;
      tx_strobe <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_strobe <= 1'b0;
          if (pick_any) begin
            shifter <= buf_data[pick_idx];
            count   <= buf_len[pick_idx];
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_ready && !tx_strobe) begin
            tx_strobe <= 1'b1;
            tx_data   <= shifter[REC_W-1 -: 8];
            shifter   <= {shifter[REC_W-9:0], 8'h00};
            count     <= count - 1'b1;
            if (count == LEN_W'(1))
              state <= IDLE;
          end else begin
            tx_strobe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_serializer.sv
// Scoreboard bench for log_serializer: expected bytes are queued
// when records are offered and popped as strobes appear.
module tb_log_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   ch_valid;
  logic [191:0] ch_data;
  logic [11:0]  ch_len;
  logic [2:0]   ch_ready;
  logic [2:0]   ch_inhibit;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_strobe;
  logic         busy;
  logic [23:0]  drop_count;

  logic rdy_base;
  logic rdy_rnd;
  bit   rand_rdy;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_strobe = 0;
  logic [7:0] exp_q[$];
  logic prev_strobe = 1'b0;

  assign tx_ready = rand_rdy ? rdy_rnd : rdy_base;

  always #5 clk = ~clk;

  log_serializer #(
    .N_CH(3), .REC_BYTES(8), .LEN_W(4), .DROP_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_len(ch_len),
    .ch_ready(ch_ready),
    .ch_inhibit(ch_inhibit),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_strobe(tx_strobe),
    .busy(busy),
    .drop_count(drop_count)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rdy_rnd = 1'($urandom_range(0, 1));
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (tx_strobe) begin
        n_strobe++;
        check("spacing", 32'(prev_strobe), 0);
        check("q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      prev_strobe = tx_strobe;
    end
  end

  task automatic push_rec(logic [63:0] d, int l);
    int n;
    n = (l > 8) ? 8 : l;
    for (int k = 0; k < n; k++)
      exp_q.push_back(d[63-8*k -: 8]);
  endtask

  task automatic offer(int ch, logic [63:0] d, logic [3:0] l);
    @(negedge clk);
    ch_data[ch*64 +: 64] = d;
    ch_len[ch*4 +: 4]    = l;
    ch_valid[ch]         = 1'b1;
    @(negedge clk);
    ch_valid[ch] = 1'b0;
  endtask

  task automatic drain(string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 3000), 1);
  endtask

  function automatic logic [7:0] dcnt(int ch);
    return drop_count[ch*8 +: 8];
  endfunction

  int s0;
  int t;

  initial begin
    reset      = 1'b1;
    ch_valid   = '0;
    ch_data    = '0;
    ch_len     = '0;
    ch_inhibit = '0;
    rdy_base   = 1'b0;
    rand_rdy   = 1'b0;
    #1;
    check("rst_ready", 32'(ch_ready), 0);
    check("rst_strobe", 32'(tx_strobe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_data", 32'(tx_data), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(ch_ready), 32'h7);

    // Basic four-byte record on ch0.
    rdy_base = 1'b1;
    s0 = n_strobe;
    push_rec(64'hAABBCCDD_11223344, 4);
    offer(0, 64'hAABBCCDD_11223344, 4'd4);
    drain("t1_drain");
    check("t1_count", 32'(n_strobe - s0), 4);
    check("t1_busy", 32'(busy), 0);

    // ch0 and ch2 in the same cycle: ch0 first, then ch2.
    s0 = n_strobe;
    push_rec(64'h0102030405060708, 3);
    push_rec(64'hF1F2F3F4F5F6F7F8, 5);
    @(negedge clk);
    ch_data[0 +: 64]   = 64'h0102030405060708;
    ch_len[0 +: 4]     = 4'd3;
    ch_data[128 +: 64] = 64'hF1F2F3F4F5F6F7F8;
    ch_len[8 +: 4]     = 4'd5;
    ch_valid           = 3'b101;
    @(negedge clk);
    ch_valid = '0;
    drain("t2_drain");
    check("t2_count", 32'(n_strobe - s0), 8);
    check("t2_drop0", 32'(dcnt(0)), 0);
    check("t2_drop2", 32'(dcnt(2)), 0);

    // len=0 is ignored; len=12 clamps to 8 bytes.
    s0 = n_strobe;
    offer(1, 64'h1234567812345678, 4'd0);
    repeat (5) @(negedge clk);
    check("len0_ready", 32'(ch_ready), 32'h7);
    check("len0_drop", 32'(dcnt(1)), 0);
    check("len0_none", 32'(n_strobe - s0), 0);
    push_rec(64'h8877665544332211, 12);
    offer(0, 64'h8877665544332211, 4'd12);
    drain("len12_drain");
    check("len12_count", 32'(n_strobe - s0), 8);

    // Drops on ch1 while SEND stalls and the buffer is full.
    rdy_base = 1'b0;
    s0 = n_strobe;
    push_rec(64'hA1A2A3A4A5A6A7A8, 2);
    push_rec(64'hB1B2B3B4B5B6B7B8, 3);
    offer(1, 64'hA1A2A3A4A5A6A7A8, 4'd2);
    @(negedge clk);
    offer(1, 64'hB1B2B3B4B5B6B7B8, 4'd3);
    check("drop_none", 32'(dcnt(1)), 0);
    offer(1, 64'hC1C2C3C4C5C6C7C8, 4'd4);
    check("drop_one", 32'(dcnt(1)), 1);
    @(negedge clk);
    ch_valid[1] = 1'b1;
    repeat (300) @(negedge clk);
    ch_valid[1] = 1'b0;
    check("drop_sat", 32'(dcnt(1)), 255);
    check("stall_none", 32'(n_strobe - s0), 0);
    rdy_base = 1'b1;
    drain("t4_drain");
    check("t4_count", 32'(n_strobe - s0), 5);
    check("t4_drop0", 32'(dcnt(0)), 0);

    // Inhibited ch2 holds its record until released.
    ch_inhibit = 3'b100;
    s0 = n_strobe;
    push_rec(64'h5A5B5C5D5E5F6061, 6);
    offer(2, 64'h5A5B5C5D5E5F6061, 4'd6);
    repeat (20) @(negedge clk);
    check("inh_none", 32'(n_strobe - s0), 0);
    check("inh_busy", 32'(busy), 0);
    check("inh_ready", 32'(ch_ready[2]), 0);
    ch_inhibit = '0;
    drain("inh_drain");
    check("inh_count", 32'(n_strobe - s0), 6);

    // Random ready toggling over a full eight-byte record.
    rand_rdy = 1'b1;
    s0 = n_strobe;
    push_rec(64'h0F1E2D3C4B5A6978, 8);
    offer(0, 64'h0F1E2D3C4B5A6978, 4'd8);
    drain("rnd_drain");
    rand_rdy = 1'b0;
    check("rnd_count", 32'(n_strobe - s0), 8);

    // Reset in the middle of a record.
    s0 = n_strobe;
    push_rec(64'hDEADBEEFCAFEF00D, 8);
    offer(0, 64'hDEADBEEFCAFEF00D, 4'd8);
    t = 0;
    while (n_strobe - s0 < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_reach", 32'(t < 200), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_strobe", 32'(tx_strobe), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(ch_ready), 0);
    check("mid_drop", 32'(drop_count), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel", 32'(ch_ready), 32'h7);
    s0 = n_strobe;
    repeat (20) @(negedge clk);
    check("mid_quiet", 32'(n_strobe - s0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
